// File: rtl/xoodoo_sca_pkg.sv
// Shared definitions for the masked Xoodoo round controller: round constants,
// FSM state encoding and the n_rounds legality rule.
package xoodoo_sca_pkg;

  localparam int NR_MAX = 12;

  // Round constants for rounds 0..11 of the 12-round Xoodoo schedule.
  localparam logic [31:0] RC_TABLE [0:NR_MAX-1] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A run is legal when it has 1..12 rounds and fills whole groups of rpc rounds.
  function automatic logic n_rounds_legal(input logic [3:0] n, input int rpc);
    return (n != 4'd0) && (int'(n) <= NR_MAX) && ((int'(n) % rpc) == 0);
  endfunction

endpackage

// File: rtl/xoodoo_rc_rom.sv
// Combinational round-constant lookup: round index (0..11) -> 32-bit constant.
// Indices outside the schedule return zero.
module xoodoo_rc_rom
  import xoodoo_sca_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [31:0] rc
);

  always_comb begin
    rc = '0;
    if (idx < 4'(NR_MAX)) rc = RC_TABLE[idx];
  end

endmodule

// File: rtl/xoodoo_rc_sequencer.sv
// Round controller for masked Xoodoo: steps through the last n_rounds rounds at
// RPC rounds per cycle. Build macro XOODOO_RDI_STALL_EN gates rounds on rdi_valid.
module xoodoo_rc_sequencer
  import xoodoo_sca_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       n_rounds,
  input  logic             rdi_valid,
  output logic             rdi_ready,
  output logic             round_en,
  output logic [32*RPC-1:0] rc_o,
  output logic [11:0]      round_oh,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  // Handshake: in RUN, a group of RPC rounds is applied (round_en) in exactly the
  // cycles where the randomness is consumed (rdi_ready); rdi_valid may only hold
  // the sequencer back, it never skips a group.

  localparam logic [3:0] RPC_STEP = 4'(RPC);

  state_t              state, state_nxt;
  logic [3:0]          idx, idx_nxt;
  logic                advance;
  logic                legal;
  logic [32*RPC-1:0]   rc_nxt;

  assign legal = n_rounds_legal(n_rounds, RPC);

`ifdef XOODOO_RDI_STALL_EN
  assign advance = (state == ST_RUN) && rdi_valid;
`else
  logic unused_rdi_valid;
  assign unused_rdi_valid = rdi_valid;
  assign advance = (state == ST_RUN);
`endif

  assign round_en  = advance;
  assign rdi_ready = advance;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (start && legal) begin
          state_nxt = ST_RUN;
          idx_nxt   = 4'(NR_MAX) - n_rounds;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if ((idx + RPC_STEP) < 4'(NR_MAX)) begin
            idx_nxt = idx + RPC_STEP;
          end else begin
            state_nxt = ST_DONE;
            idx_nxt   = '0;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Constants are looked up for the index the next cycle will present, so the
  // output registers always hold the constants matching round_oh.
  for (genvar k = 0; k < RPC; k++) begin : g_lane
    logic [3:0] lane_idx;
    assign lane_idx = idx_nxt + 4'(k);
    xoodoo_rc_rom u_rom (
      .idx (lane_idx),
      .rc  (rc_nxt[32*k +: 32])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      rc_o     <= '0;
      round_oh <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err   <= (state == ST_IDLE) && start && !legal;
      if (state_nxt == ST_RUN) begin
        rc_o     <= rc_nxt;
        round_oh <= 12'd1 << idx_nxt;
      end else begin
        rc_o     <= '0;
        round_oh <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xoodoo_rc_sequencer.sv
// Bench for xoodoo_rc_sequencer: one instance at RPC=1 and one at RPC=4, checked
// against a round-position model built from the published constant table.
module tb_xoodoo_rc_sequencer;
  import xoodoo_sca_pkg::*;

  localparam logic [31:0] RC_REF [0:11] = '{
    32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
    32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
  };

  typedef struct packed {
    logic [127:0] rc;
    logic [11:0]  oh;
    logic         en;
    logic         rdy;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   st;
  } obs_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1, v1, rdy1, en1, busy1, done1, err1;
  logic [3:0]  nr1;
  logic [31:0] rc1;
  logic [11:0] oh1;
  logic [1:0]  st1;

  logic         start4, v4, rdy4, en4, busy4, done4, err4;
  logic [3:0]   nr4;
  logic [127:0] rc4;
  logic [11:0]  oh4;
  logic [1:0]   st4;

  int checks = 0;
  int failures = 0;

  xoodoo_rc_sequencer #(.RPC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .n_rounds(nr1), .rdi_valid(v1),
    .rdi_ready(rdy1), .round_en(en1), .rc_o(rc1), .round_oh(oh1),
    .busy(busy1), .done(done1), .err(err1), .state_dbg(st1)
  );

  xoodoo_rc_sequencer #(.RPC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .n_rounds(nr4), .rdi_valid(v4),
    .rdi_ready(rdy4), .round_en(en4), .rc_o(rc4), .round_oh(oh4),
    .busy(busy4), .done(done4), .err(err4), .state_dbg(st4)
  );

  // driver tasks
  task automatic drive(input int w, input logic st, input logic [3:0] n, input logic v);
    if (w == 0) begin start1 = st; nr1 = n; v1 = v; end
    else        begin start4 = st; nr4 = n; v4 = v; end
  endtask

  function automatic obs_t get_obs(input int w);
    obs_t o;
    if (w == 0) begin
      o.rc = {96'd0, rc1}; o.oh = oh1; o.en = en1; o.rdy = rdy1;
      o.busy = busy1; o.done = done1; o.err = err1; o.st = st1;
    end else begin
      o.rc = rc4; o.oh = oh4; o.en = en4; o.rdy = rdy4;
      o.busy = busy4; o.done = done4; o.err = err4; o.st = st4;
    end
    return o;
  endfunction

  // scoreboard comparison
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int w, input string tag);
    obs_t o;
    o = get_obs(w);
    chk({tag, "_rc"},   o.rc,   128'd0);
    chk({tag, "_oh"},   o.oh,   128'd0);
    chk({tag, "_busy"}, o.busy, 128'd0);
    chk({tag, "_done"}, o.done, 128'd0);
    chk({tag, "_err"},  o.err,  128'd0);
    chk({tag, "_en"},   o.en,   128'd0);
    chk({tag, "_rdy"},  o.rdy,  128'd0);
    chk({tag, "_st"},   o.st,   128'(ST_IDLE));
  endtask

  // mode 0: randomness always present; 1: random gaps; 2: 3-cycle gap at round 5.
  // poke: throw random start requests at the block while it is busy.
  task automatic run_perm(input int w, input int n, input int mode, input bit poke);
    int rpc, pos, phase, cyc, stalls, stall_ct;
    obs_t o;
    logic v, exp_adv;
    logic [127:0] exp_rc;
    logic [11:0] exp_oh;
    rpc = (w == 0) ? 1 : 4;
    @(negedge clk); drive(w, 1'b1, 4'(n), 1'b1);
    @(negedge clk); drive(w, 1'b0, 4'(n), 1'b1);
    pos = 12 - n; phase = 1; cyc = 1; stalls = 0; stall_ct = 0;
    while (phase != 0 && cyc < 200) begin
      o = get_obs(w);
      chk("err_quiet", o.err, 128'd0);
      if (phase == 1) begin
        exp_rc = '0;
        for (int k = 0; k < rpc; k++) exp_rc[32*k +: 32] = RC_REF[pos+k];
        exp_oh = 12'd1 << pos;
        chk("run_rc", o.rc, exp_rc);
        chk("run_oh", o.oh, 128'(exp_oh));
        chk("run_busy", o.busy, 128'd1);
        chk("run_done", o.done, 128'd0);
        chk("run_st", o.st, 128'(ST_RUN));
        if (mode == 1)      v = ($urandom_range(0, 3) != 0);
        else if (mode == 2) v = !(pos == 5 && stall_ct < 3);
        else                v = 1'b1;
        if (poke) drive(w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), v);
        else      drive(w, 1'b0, 4'(n), v);
`ifdef XOODOO_RDI_STALL_EN
        exp_adv = v;
`else
        exp_adv = 1'b1;
`endif
        #1;
        o = get_obs(w);
        chk("run_en", o.en, 128'(exp_adv));
        chk("run_rdy", o.rdy, 128'(exp_adv));
        if (exp_adv) begin
          pos += rpc;
          if (pos >= 12) phase = 2;
        end else begin
          stalls++;
          stall_ct++;
        end
      end else begin
        chk("done_pulse", o.done, 128'd1);
        chk("done_busy", o.busy, 128'd1);
        chk("done_rc", o.rc, 128'd0);
        chk("done_oh", o.oh, 128'd0);
        chk("done_en", o.en, 128'd0);
        chk("done_st", o.st, 128'(ST_DONE));
        chk("done_lat", 128'(cyc), 128'(n / rpc + stalls + 1));
        if (poke) drive(w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
        phase = 0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("run_timeout", 128'(phase), 128'd0);
    drive(w, 1'b0, 4'(n), 1'b1);
    check_idle(w, "post");
  endtask

  task automatic err_test(input int w, input int n);
    obs_t o;
    @(negedge clk); drive(w, 1'b1, 4'(n), 1'b1);
    @(negedge clk); drive(w, 1'b0, 4'(n), 1'b1);
    o = get_obs(w);
    chk("err_pulse", o.err, 128'd1);
    chk("err_busy", o.busy, 128'd0);
    chk("err_st", o.st, 128'(ST_IDLE));
    chk("err_oh", o.oh, 128'd0);
    @(negedge clk);
    o = get_obs(w);
    chk("err_clear", o.err, 128'd0);
    chk("err_busy2", o.busy, 128'd0);
  endtask

  task automatic abort_test();
    obs_t o;
    @(negedge clk); drive(0, 1'b1, 4'd12, 1'b1);
    @(negedge clk); drive(0, 1'b0, 4'd12, 1'b1);
    repeat (7) @(negedge clk);
    o = get_obs(0);
    chk("abort_pre_rc", o.rc, 128'(RC_REF[7]));
    chk("abort_pre_oh", o.oh, 128'(12'h080));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "abort");
    repeat (3) begin
      @(negedge clk);
      o = get_obs(0);
      chk("abort_no_done", o.done, 128'd0);
    end
  endtask

  initial begin
    int w, n;
    drive(0, 1'b0, 4'd0, 1'b0);
    drive(1, 1'b0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_idle(0, "rst1");
    check_idle(1, "rst4");
    rst = 1'b0;

    run_perm(0, 12, 0, 1'b0);
    run_perm(0, 6, 0, 1'b0);
    run_perm(1, 12, 0, 1'b0);
    run_perm(1, 8, 0, 1'b0);
    run_perm(0, 12, 2, 1'b0);
    run_perm(0, 1, 0, 1'b0);

    err_test(1, 6);
    err_test(1, 0);
    err_test(1, 13);
    err_test(0, 0);
    err_test(0, 14);

    run_perm(1, 12, 0, 1'b1);
    abort_test();
    run_perm(0, 12, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      w = int'($urandom_range(0, 1));
      n = (w == 0) ? int'($urandom_range(1, 12)) : 4 * int'($urandom_range(1, 3));
      run_perm(w, n, 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
